// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: 32 x 16 register file, accessible over MDC/MDIO and by local preload.
// Build option: define MDIO_PRE_SUPPRESS_EN to accept a single preamble 1 ahead of the start bits.
module mdio_slave #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic        phy_mdc,
    inout  wire         phy_mdio,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [15:0] ld_dat,
    output logic        reg_wr_stb,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_dat,
    output logic        reg_rd_stb
);

    localparam int PCW = $clog2(PRE_LEN + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_OPC   = 3'd2;
    localparam logic [2:0] S_PHY_A = 3'd3;
    localparam logic [2:0] S_REG_A = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_REG_D = 3'd6;

    function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] v);
        if (v == PCW'(PRE_LEN))
            return v;
        return v + PCW'(1);
    endfunction

    logic        mdc_p0, mdc_p1, mdc_p2;
    logic        mdio_p0, mdio_p1;
    logic        mdc_rise, mdc_fall, bit_p1;

    logic [2:0]     state;
    logic [PCW-1:0] pre_cnt;
    logic           pre_ok;
    logic [3:0]     bit_cnt;
    logic           op_hi;
    logic           is_rd;
    logic [3:0]     phy_sh;
    logic           sel;
    logic [4:0]     reg_addr;
    logic [14:0]    wr_sh;
    logic           rd_arm;

    logic [15:0]    regs [32];

    logic           mdio_oe;
    logic           mdio_do;
    logic           rd_act;
    logic [4:0]     rd_cnt;
    logic [15:0]    rd_sh;

    assign phy_mdio = mdio_oe ? mdio_do : 1'bz;

    // Stage p0/p1: two-flop synchronizers; p2: MDC history for edge detection
    always_ff @(posedge clk_25M) begin
        mdc_p0  <= phy_mdc;
        mdc_p1  <= mdc_p0;
        mdc_p2  <= mdc_p1;
        mdio_p0 <= phy_mdio;
        mdio_p1 <= mdio_p0;
    end

    assign mdc_rise = mdc_p1 & ~mdc_p2;
    assign mdc_fall = ~mdc_p1 & mdc_p2;
    assign bit_p1   = mdio_p1;

`ifdef MDIO_PRE_SUPPRESS_EN
    assign pre_ok = (pre_cnt != '0);
`else
    assign pre_ok = (pre_cnt >= PCW'(PRE_LEN));
`endif

    // Frame decoder and register file; a master write is ordered after the local load so it wins
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            bit_cnt     <= '0;
            op_hi       <= 1'b0;
            is_rd       <= 1'b0;
            sel         <= 1'b0;
            rd_arm      <= 1'b0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_dat  <= '0;
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else begin
            reg_wr_stb <= 1'b0;
            if (ld_en)
                regs[ld_addr] <= ld_dat;
            if (mdc_rise) begin
                rd_arm <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (bit_p1) begin
                            pre_cnt <= sat_inc(pre_cnt);
                        end else if (pre_ok) begin
                            state   <= S_START;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    S_START: begin
                        bit_cnt <= '0;
                        state   <= bit_p1 ? S_OPC : S_IDLE;
                    end
                    S_OPC: begin
                        if (bit_cnt == 4'd0) begin
                            op_hi   <= bit_p1;
                            bit_cnt <= 4'd1;
                        end else begin
                            bit_cnt <= '0;
                            if (op_hi != bit_p1) begin
                                is_rd <= op_hi;
                                state <= S_PHY_A;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_PHY_A: begin
                        phy_sh <= {phy_sh[2:0], bit_p1};
                        if (bit_cnt == 4'd4) begin
                            sel     <= ({phy_sh, bit_p1} == PHY_ADDR);
                            bit_cnt <= '0;
                            state   <= S_REG_A;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_REG_A: begin
                        reg_addr <= {reg_addr[3:0], bit_p1};
                        if (bit_cnt == 4'd4) begin
                            rd_arm  <= sel & is_rd;
                            bit_cnt <= '0;
                            state   <= S_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_TA: begin
                        if (bit_cnt == 4'd1) begin
                            bit_cnt <= '0;
                            state   <= S_REG_D;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_REG_D: begin
                        wr_sh <= {wr_sh[13:0], bit_p1};
                        if (bit_cnt == 4'd15) begin
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                            state   <= S_IDLE;
                            if (sel && !is_rd) begin
                                regs[reg_addr] <= {wr_sh, bit_p1};
                                reg_wr_stb     <= 1'b1;
                                reg_wr_addr    <= reg_addr;
                                reg_wr_dat     <= {wr_sh, bit_p1};
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Read driver: advances on MDC falls only; fall 0 snapshots, 1 drives TA 0, 2..17 data, 18 releases
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            mdio_oe    <= 1'b0;
            rd_act     <= 1'b0;
            rd_cnt     <= '0;
            reg_rd_stb <= 1'b0;
        end else begin
            reg_rd_stb <= 1'b0;
            if (mdc_fall) begin
                if (rd_arm) begin
                    rd_sh  <= regs[reg_addr];
                    rd_act <= 1'b1;
                    rd_cnt <= '0;
                end else if (rd_act) begin
                    rd_cnt <= rd_cnt + 5'd1;
                    if (rd_cnt == 5'd0) begin
                        mdio_oe <= 1'b1;
                        mdio_do <= 1'b0;
                    end else if (rd_cnt <= 5'd16) begin
                        mdio_do <= rd_sh[15];
                        rd_sh   <= {rd_sh[14:0], 1'b0};
                    end else begin
                        mdio_oe    <= 1'b0;
                        rd_act     <= 1'b0;
                        reg_rd_stb <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
